// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for a JK flip-flop stage: buffers hold/clear/set/toggle commands,
// drives j/k for len+1 cycles each, and models the expected Q to flag divergence.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  input  logic             q,
  input  logic             check_en,
  output logic             q_exp,
  output logic             mismatch,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [1:0]       op;
    logic [LEN_W-1:0] len;
  } cmd_t;

  typedef enum logic {IDLE, DRIVE} state_e;

  cmd_t             mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_e           state_q, state_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic             j_q, j_d, k_q, k_d;
  logic             q_exp_q, q_exp_d, mm_q, mm_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic             full, empty, push, pop;
  cmd_t             head;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    push     = cmd_valid && !full;
    head     = mem_q[rd_ptr_q];
    pop      = 1'b0;
    state_d  = state_q;
    remain_d = remain_q;
    j_d      = j_q;
    k_d      = k_q;
    done_d   = done_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    case (state_q)
      IDLE: if (!empty) pop = 1'b1;
      DRIVE: begin
        if (remain_q != '0) begin
          remain_d = remain_q - LEN_W'(1);
        end else begin
          done_d = done_q + CNT_W'(1);
          // Chain straight into the next command so j/k never bubble to 00.
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
            j_d     = 1'b0;
            k_d     = 1'b0;
          end
        end
      end
    endcase

    if (pop) begin
      state_d  = DRIVE;
      j_d      = head.op[1];
      k_d      = head.op[0];
      remain_d = head.len;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    case ({j_q, k_q})
      2'b01:   q_exp_d = 1'b0;
      2'b10:   q_exp_d = 1'b1;
      2'b11:   q_exp_d = ~q_exp_q;
      default: q_exp_d = q_exp_q;
    endcase
    mm_d = mm_q | (check_en & (q != q_exp_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      remain_q <= '0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      q_exp_q  <= 1'b0;
      mm_q     <= 1'b0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      remain_q <= remain_d;
      j_q      <= j_d;
      k_q      <= k_d;
      q_exp_q  <= q_exp_d;
      mm_q     <= mm_d;
      done_q   <= done_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{op: cmd_op, len: cmd_len};
  end

  assign cmd_ready = !full;
  assign busy      = (state_q == DRIVE) || !empty;
  assign j         = j_q;
  assign k         = k_q;
  assign q_exp     = q_exp_q;
  assign mismatch  = mm_q;
  assign done_cnt  = done_q;

endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
Upstream driver for the JK flip-flop stage. Accepts hold/reset/set/toggle commands over a valid/ready interface and buffers them in a small FIFO. Drives the flip-flop's j/k pins for a programmable number of cycles per command. Keeps a cycle-accurate model of the expected flip-flop output, compares it against the returned q, and flags any divergence.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >=2
LEN_W, 4, width of per-command repeat field
CNT_W, 8, width of completed-command counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; equals !full
cmd_op  in  2  00 hold (j0k0), 01 clear (j0k1), 10 set (j1k0), 11 toggle (j1k1)
cmd_len  in  LEN_W  command drives j/k for cmd_len+1 cycles
j  out  1  to flip-flop J, registered
k  out  1  to flip-flop K, registered
q  in  1  returned flip-flop Q
check_en  in  1  enables comparison of q against q_exp
q_exp  out  1  modelled flip-flop state, registered
mismatch  out  1  sticky compare-failure flag
busy  out  1  high in DRIVE or when FIFO non-empty
done_cnt  out  CNT_W  completed commands, wraps modulo 2^CNT_W

Behaviour:
- Reset (synchronous, highest priority):
  - FIFO flushed; count 0; FSM to IDLE.
  - j=0, k=0, q_exp=0, mismatch=0, done_cnt=0, busy=0.
  - cmd_ready=1 from the cycle after reset deasserts.
  - A push presented during reset is dropped.
  - Reset mid-command abandons the command; it does not increment done_cnt.
- Push:
  - Occurs at an edge where cmd_valid && cmd_ready. Stores {cmd_op, cmd_len}.
  - cmd_ready depends only on full. A full FIFO refuses a push even if a pop occurs in the same cycle.
  - No bypass path: an empty FIFO with a push still takes one cycle before the command is popped.
- FSM states: IDLE, DRIVE.
  - IDLE: j=k=0. At an edge where the FIFO is non-empty (pre-edge count>0), pop the head, load j/k from op, load remain=len, go to DRIVE.
  - DRIVE: each edge, if remain>0 then remain-1 and j/k held.
  - DRIVE at remain==0 (command has driven len+1 cycles): done_cnt+1.
    - FIFO non-empty: pop the next command in the same edge. No bubble; j/k change directly to the new values.
    - FIFO empty: j=k=0, go to IDLE.
  - Simultaneous push and pop in a non-full FIFO: both take effect; count unchanged.
- Latency: a command pushed at edge t into an empty, idle sequencer has j/k valid from edge t+1 through edge t+1+len+1, exclusive. Example: len=0 drives exactly one cycle.
- Model:
  - At every edge, q_exp updates from the pre-edge j/k: 00 hold, 01 to 0, 10 to 1, 11 invert.
  - This matches a flip-flop clocked by the same clk and reset by the same reset.
- Check:
  - At any edge with check_en=1 and pre-edge q != q_exp, mismatch is set to 1.
  - mismatch stays set until reset; check_en=0 does not clear it.
- Pointers:
  - Read and write pointers wrap modulo DEPTH; count spans 0..DEPTH.
  - Full = count==DEPTH; empty = count==0.
- done_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Reset then single push (op=10, len=2) at edge t:
  - j=1, k=0 for edges t+1..t+3, then j=k=0.
  - q_exp=1 after edge t+2.
  - done_cnt=1, busy falls after the command completes.
  - With the flip-flop attached and check_en=1, mismatch stays 0.
- Back-to-back toggle (op=11, len=0) x4 pushed while busy:
  - j=k=1 for 4 consecutive cycles with no gaps.
  - q_exp sequence 1,0,1,0; done_cnt=4.
- Fill FIFO with 4 commands (len=15) while DRIVE is active:
  - cmd_ready=0 once count=4.
  - A 5th push held by cmd_valid is accepted only at the edge after a pop frees an entry.
- Clear/hold ordering: push set(len0), hold(len3), clear(len0):
  - q_exp goes 1, stays 1 for 4 cycles, then 0.
  - j/k go 10, 00, 00, 00, 00, 01.
- Force q=0 while q_exp=1 with check_en=1:
  - mismatch=1 at the next edge.
  - Deasserting check_en keeps mismatch=1; reset clears it.
- Assert reset during DRIVE with 3 entries queued:
  - Next cycle j=k=0, busy=0, count=0, q_exp=0, done_cnt=0, cmd_ready=1.
  - Subsequent push (op=01, len=0) issues normally.
